// File: rtl/ctrl_sequencer.sv
// Multi-cycle control sequencer for the arithmetic processor datapath.
// Latches one instruction per run request and steps IDLE -> T1 (-> T2 -> T3),
// producing decoder indices and qualifier strobes from the registered state and IR.
module ctrl_sequencer #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned OP_W  = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      run,
    input  logic [OP_W+2*IDX_W-1:0]   instr,
    output logic [IDX_W-1:0]          regIndex,
    output logic                      reg_en,
    output logic [IDX_W-1:0]          triIndex,
    output logic                      tri_en,
    output logic                      din_out,
    output logic                      ain,
    output logic                      gin,
    output logic                      gout,
    output logic                      addsub,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned IrW = OP_W + 2 * IDX_W;

    localparam logic [OP_W-1:0] OpMv  = OP_W'(0);
    localparam logic [OP_W-1:0] OpMvi = OP_W'(1);
    localparam logic [OP_W-1:0] OpAdd = OP_W'(2);
    localparam logic [OP_W-1:0] OpSub = OP_W'(3);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StT1   = 2'd1,
        StT2   = 2'd2,
        StT3   = 2'd3
    } state_e;

    state_e           state_q;
    logic [IrW-1:0]   ir_q;
    logic [OP_W-1:0]  op;
    logic [IDX_W-1:0] rx;
    logic [IDX_W-1:0] ry;
    logic             is_alu;

    assign op     = ir_q[IrW-1 -: OP_W];
    assign rx     = ir_q[2*IDX_W-1 -: IDX_W];
    assign ry     = ir_q[IDX_W-1:0];
    assign is_alu = (op == OpAdd) || (op == OpSub);

    // State and instruction register; run is only honoured in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            ir_q    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (run) begin
                        ir_q    <= instr;
                        state_q <= StT1;
                    end
                end
                // mv, mvi and undefined opcodes finish in T1.
                StT1:    state_q <= is_alu ? StT2 : StIdle;
                StT2:    state_q <= StT3;
                StT3:    state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Moore output decode; indices are forced to 0 whenever their enable is low.
    always_comb begin
        regIndex = '0;
        reg_en   = 1'b0;
        triIndex = '0;
        tri_en   = 1'b0;
        din_out  = 1'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        gout     = 1'b0;
        addsub   = 1'b0;
        done     = 1'b0;
        busy     = (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StT1: begin
                case (op)
                    OpMv: begin
                        triIndex = ry;
                        tri_en   = 1'b1;
                        regIndex = rx;
                        reg_en   = 1'b1;
                        done     = 1'b1;
                    end
                    OpMvi: begin
                        din_out  = 1'b1;
                        regIndex = rx;
                        reg_en   = 1'b1;
                        done     = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        triIndex = rx;
                        tri_en   = 1'b1;
                        ain      = 1'b1;
                    end
                    // Undefined opcodes execute as a one-cycle NOP.
                    default: done = 1'b1;
                endcase
            end
            StT2: begin
                triIndex = ry;
                tri_en   = 1'b1;
                gin      = 1'b1;
                addsub   = (op == OpSub);
            end
            StT3: begin
                gout     = 1'b1;
                regIndex = rx;
                reg_en   = 1'b1;
                done     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: a table of {reset, run, instr, expected outputs}
// applied one clock per entry, then a run-held-high undefined-opcode sequence.
module tb_ctrl_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [10:0] instr;
    logic [3:0]  regIndex;
    logic        reg_en;
    logic [3:0]  triIndex;
    logic        tri_en;
    logic        din_out;
    logic        ain;
    logic        gin;
    logic        gout;
    logic        addsub;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    ctrl_sequencer #(
        .IDX_W(4),
        .OP_W (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .run     (run),
        .instr   (instr),
        .regIndex(regIndex),
        .reg_en  (reg_en),
        .triIndex(triIndex),
        .tri_en  (tri_en),
        .din_out (din_out),
        .ain     (ain),
        .gin     (gin),
        .gout    (gout),
        .addsub  (addsub),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // {regIndex, reg_en, triIndex, tri_en, din_out, ain, gin, gout, addsub, busy, done}
    logic [16:0] act;
    assign act = {regIndex, reg_en, triIndex, tri_en, din_out, ain, gin, gout, addsub,
                  busy, done};

    typedef struct {
        string       name;
        logic        rst;
        logic        run;
        logic [10:0] instr;
        logic [16:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [10:0] mk(input logic [2:0] op, input logic [3:0] rx,
                                       input logic [3:0] ry);
        return {op, rx, ry};
    endfunction

    function automatic logic [16:0] ex(input logic [3:0] ri, input logic re,
                                       input logic [3:0] ti, input logic te,
                                       input logic dn, input logic a, input logic g,
                                       input logic go, input logic as, input logic bz,
                                       input logic dd);
        return {ri, re, ti, te, dn, a, g, go, as, bz, dd};
    endfunction

    function automatic void v(input string name, input logic rst, input logic r,
                              input logic [10:0] ins, input logic [16:0] e);
        vec_t t;
        t.name  = name;
        t.rst   = rst;
        t.run   = r;
        t.instr = ins;
        t.exp   = e;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic [16:0] want);
        int drivers;
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
        drivers = int'(tri_en) + int'(din_out) + int'(gout);
        checks++;
        if (drivers > 1 || (!reg_en && regIndex != 4'd0) || (!tri_en && triIndex != 4'd0)) begin
            errors++;
            $display("FAIL %s_invariant got %h want one driver and zero idle indices",
                     name, act);
        end
    endtask

    task automatic step(input string name, input logic [16:0] want);
        @(posedge clk);
        #1;
        check(name, want);
    endtask

    localparam logic [16:0] Z = 17'd0;

    initial begin
        reset = 1'b1;
        run   = 1'b1;
        instr = 11'd0;

        // Reset held with run high, then mv R2,R5.
        v("rst0",      1, 1, mk(0, 2, 5),  Z);
        v("rst1",      1, 1, mk(0, 2, 5),  Z);
        v("mv_t1",     0, 1, mk(0, 2, 5),  ex(2, 1, 5, 1, 0, 0, 0, 0, 0, 1, 1));
        v("mv_idle",   0, 0, mk(0, 2, 5),  Z);
        // mvi to register 15.
        v("mvi_t1",    0, 1, mk(1, 15, 3), ex(15, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1));
        v("mvi_idle",  0, 0, mk(1, 15, 3), Z);
        // sub R4,R9.
        v("sub_t1",    0, 1, mk(3, 4, 9),  ex(0, 0, 4, 1, 0, 1, 0, 0, 0, 1, 0));
        v("sub_t2",    0, 0, mk(3, 4, 9),  ex(0, 0, 9, 1, 0, 0, 1, 0, 1, 1, 0));
        v("sub_t3",    0, 0, mk(3, 4, 9),  ex(4, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        v("sub_idle",  0, 0, mk(3, 4, 9),  Z);
        // add R1,R2; instr and run change while busy and must be ignored.
        v("add_t1",    0, 1, mk(2, 1, 2),  ex(0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0));
        v("imm_t2",    0, 1, mk(0, 7, 7),  ex(0, 0, 2, 1, 0, 0, 1, 0, 0, 1, 0));
        v("imm_t3",    0, 1, mk(0, 7, 7),  ex(1, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        v("imm_idle",  0, 0, mk(0, 7, 7),  Z);
        // Reset during T2 of add R3,R3 aborts without done.
        v("abt_t1",    0, 1, mk(2, 3, 3),  ex(0, 0, 3, 1, 0, 1, 0, 0, 0, 1, 0));
        v("abt_t2",    0, 0, mk(2, 3, 3),  ex(0, 0, 3, 1, 0, 0, 1, 0, 0, 1, 0));
        v("abt_rst",   1, 0, mk(2, 3, 3),  Z);
        v("abt_idle",  0, 0, mk(2, 3, 3),  Z);
        // mv R3,R3 back-to-back with run held: 2-cycle issue interval.
        v("mv33_t1",   0, 1, mk(0, 3, 3),  ex(3, 1, 3, 1, 0, 0, 0, 0, 0, 1, 1));
        v("mv33_gap",  0, 1, mk(0, 3, 3),  Z);
        v("mv33_t1b",  0, 1, mk(0, 3, 3),  ex(3, 1, 3, 1, 0, 0, 0, 0, 0, 1, 1));
        v("mv33_end",  0, 0, mk(0, 3, 3),  Z);
        // add R15,R0 back-to-back with run held: 4-cycle issue interval.
        v("a15_t1",    0, 1, mk(2, 15, 0), ex(0, 0, 15, 1, 0, 1, 0, 0, 0, 1, 0));
        v("a15_t2",    0, 1, mk(2, 15, 0), ex(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0));
        v("a15_t3",    0, 1, mk(2, 15, 0), ex(15, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        v("a15_gap",   0, 1, mk(2, 15, 0), Z);
        v("a15_t1b",   0, 1, mk(2, 15, 0), ex(0, 0, 15, 1, 0, 1, 0, 0, 0, 1, 0));
        v("a15_t2b",   0, 0, mk(2, 15, 0), ex(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0));
        v("a15_t3b",   0, 0, mk(2, 15, 0), ex(15, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
        v("a15_end",   0, 0, mk(2, 15, 0), Z);
        // Undefined opcode 100 is a one-cycle NOP.
        v("nop100",    0, 1, mk(4, 9, 9),  ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
        v("nop_idle",  0, 0, mk(4, 9, 9),  Z);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            run   = vecs[i].run;
            instr = vecs[i].instr;
            step(vecs[i].name, vecs[i].exp);
        end

        // Undefined opcode 110 with run held: done every other cycle, no enables.
        reset = 1'b0;
        run   = 1'b1;
        instr = mk(6, 10, 5);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("nop110_%0d", i),
                 (i % 2 == 0) ? ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1) : Z);
        end
        run = 1'b0;
        step("nop110_end", Z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
